// File: rtl/loader_pkg.sv
// Shared types and geometry for the instruction-memory loader.
package loader_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        FULL    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop sync, debounce over DEBOUNCE_CYCLES stable samples, rising-edge pulse.
// Pulse is one cycle, registered, about DEBOUNCE_CYCLES+3 cycles after a clean press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    // r_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_pulse <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/instr_mem_loader.sv
// Switch-driven program loader for a 256x8 instruction memory; holds the CPU in reset while loading.
// Reads are combinational; optional last-written-word readback under LOADER_READBACK_EN.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned          DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [DATA_W-1:0]    FILL_WORD       = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_mode,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              btn_write,
    input  logic [ADDR_W-1:0] Read_Address,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_reset,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   prog_len,
    output logic              full,
    output logic [DATA_W-1:0] last_word
);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_mode_sync;
    logic              w_mode;
    logic              w_pulse;
    logic              w_wr_en;
    logic              w_clr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_prog_len;
    logic              r_full;
    logic              r_cpu_reset;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .i_btn (btn_write),
        .pulse (w_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_sync <= 2'b00;
        end else begin
            r_mode_sync <= {r_mode_sync[0], load_mode};
        end
    end

    assign w_mode = r_mode_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // A press landing on the same edge that load_mode drops still gets written.
    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        w_clr   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mode) begin
                    w_next = LOAD;
                    w_clr  = 1'b1;
                end
            end
            LOAD: begin
                w_wr_en = w_pulse;
                if (!w_mode) begin
                    w_next = RELEASE;
                end else if (w_pulse && (r_wr_ptr == {ADDR_W{1'b1}})) begin
                    w_next = FULL;
                end
            end
            FULL: begin
                if (!w_mode) begin
                    w_next = RELEASE;
                end
            end
            RELEASE: begin
                w_next = RUN;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_prog_len  <= '0;
            r_full      <= 1'b0;
            r_cpu_reset <= 1'b0;
        end else begin
            if (w_clr) begin
                r_wr_ptr   <= '0;
                r_prog_len <= '0;
            end else if (w_wr_en) begin
                r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                r_prog_len <= r_prog_len + (ADDR_W+1)'(1);
            end
            r_full      <= (w_next == FULL);
            r_cpu_reset <= (w_next != RUN);
        end
    end

    // Contents deliberately survive reset; prog_len alone decides validity.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= sw_data;
        end
    end

    assign instruction = ({1'b0, Read_Address} < r_prog_len) ? r_mem[Read_Address] : FILL_WORD;
    assign cpu_reset   = r_cpu_reset;
    assign wr_ptr      = r_wr_ptr;
    assign prog_len    = r_prog_len;
    assign full        = r_full;

`ifdef LOADER_READBACK_EN
    logic [DATA_W-1:0] r_last_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_word <= '0;
        end else if (w_clr) begin
            r_last_word <= '0;
        end else if (w_wr_en) begin
            r_last_word <= sw_data;
        end
    end

    assign last_word = r_last_word;
`else
    assign last_word = '0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with DEBOUNCE_CYCLES=4 and a non-zero fill word.
module tb_instr_mem_loader;
    import loader_pkg::*;

    localparam logic [7:0] FILL = 8'hEA;

    logic       clk;
    logic       reset;
    logic       load_mode;
    logic [7:0] sw_data;
    logic       btn_write;
    logic [7:0] Read_Address;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic [7:0] wr_ptr;
    logic [8:0] prog_len;
    logic       full;
    logic [7:0] last_word;

    int n_vec;
    int n_err;

    instr_mem_loader #(
        .DEBOUNCE_CYCLES (4),
        .FILL_WORD       (FILL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_mode    (load_mode),
        .sw_data      (sw_data),
        .btn_write    (btn_write),
        .Read_Address (Read_Address),
        .instruction  (instruction),
        .cpu_reset    (cpu_reset),
        .wr_ptr       (wr_ptr),
        .prog_len     (prog_len),
        .full         (full),
        .last_word    (last_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] d);
        sw_data   = d;
        btn_write = 1'b1;
        repeat (10) tick();
        btn_write = 1'b0;
        repeat (10) tick();
    endtask

    task automatic wait_release();
        for (int i = 0; i < 12 && dut.r_state !== RELEASE; i++) tick();
        n_vec++;
        if (dut.r_state !== RELEASE) begin
            n_err++;
            $display("FAIL release_timeout: state=%0d required=%0d", dut.r_state, RELEASE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_mode = 1'b0; btn_write = 1'b0; sw_data = 8'h00; Read_Address = 8'h05;
        repeat (3) tick();
        n_vec++; if (instruction !== FILL) begin n_err++; $display("FAIL rst_instr: got %h want %h", instruction, FILL); end
        n_vec++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL rst_cpu_reset: got %b want 0", cpu_reset); end
        n_vec++; if (prog_len !== 9'd0) begin n_err++; $display("FAIL rst_prog_len: got %0d want 0", prog_len); end
        n_vec++; if (wr_ptr !== 8'd0 || full !== 1'b0 || last_word !== 8'h00) begin
            n_err++; $display("FAIL rst_misc: wr_ptr=%h full=%b last=%h want 00/0/00", wr_ptr, full, last_word);
        end
        reset = 1'b0;
        repeat (3) tick();
        n_vec++; if (instruction !== FILL || cpu_reset !== 1'b0) begin
            n_err++; $display("FAIL post_rst: instr=%h cpu_reset=%b want %h/0", instruction, cpu_reset, FILL);
        end
    endtask

    task automatic test_basic_load();
        load_mode = 1'b1;
        repeat (6) tick();
        n_vec++; if (cpu_reset !== 1'b1 || prog_len !== 9'd0) begin
            n_err++; $display("FAIL load_entry: cpu_reset=%b prog_len=%0d want 1/0", cpu_reset, prog_len);
        end
        press(8'h41); press(8'h82); press(8'hC3);
        n_vec++; if (prog_len !== 9'd3 || wr_ptr !== 8'd3) begin
            n_err++; $display("FAIL basic_len: prog_len=%0d wr_ptr=%0d want 3/3", prog_len, wr_ptr);
        end
`ifdef LOADER_READBACK_EN
        n_vec++; if (last_word !== 8'hC3) begin n_err++; $display("FAIL basic_last: got %h want c3", last_word); end
`else
        n_vec++; if (last_word !== 8'h00) begin n_err++; $display("FAIL basic_last: got %h want 00", last_word); end
`endif
        load_mode = 1'b0;
        wait_release();
        n_vec++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL release_cpu_reset: got %b want 1", cpu_reset); end
        tick();
        n_vec++; if (dut.r_state !== RUN || cpu_reset !== 1'b0) begin
            n_err++; $display("FAIL after_release: state=%0d cpu_reset=%b want RUN/0", dut.r_state, cpu_reset);
        end
        Read_Address = 8'd0; #1;
        n_vec++; if (instruction !== 8'h41) begin n_err++; $display("FAIL rd0: got %h want 41", instruction); end
        Read_Address = 8'd1; #1;
        n_vec++; if (instruction !== 8'h82) begin n_err++; $display("FAIL rd1: got %h want 82", instruction); end
        Read_Address = 8'd2; #1;
        n_vec++; if (instruction !== 8'hC3) begin n_err++; $display("FAIL rd2: got %h want c3", instruction); end
        Read_Address = 8'd3; #1;
        n_vec++; if (instruction !== FILL) begin n_err++; $display("FAIL rd3: got %h want %h", instruction, FILL); end
    endtask

    task automatic test_bounce();
        load_mode = 1'b1;
        repeat (6) tick();
        n_vec++; if (prog_len !== 9'd0 || wr_ptr !== 8'd0 || last_word !== 8'h00) begin
            n_err++; $display("FAIL reload_clear: prog_len=%0d wr_ptr=%0d last=%h want 0/0/00", prog_len, wr_ptr, last_word);
        end
        sw_data = 8'h5A;
        btn_write = 1'b1; repeat (2) tick();
        btn_write = 1'b0; repeat (2) tick();
        btn_write = 1'b1; tick();
        btn_write = 1'b0; tick();
        btn_write = 1'b1; repeat (10) tick();
        btn_write = 1'b0; repeat (10) tick();
        n_vec++; if (wr_ptr !== 8'd1 || prog_len !== 9'd1) begin
            n_err++; $display("FAIL bounce_once: wr_ptr=%0d prog_len=%0d want 1/1", wr_ptr, prog_len);
        end
        Read_Address = 8'd0; #1;
        n_vec++; if (instruction !== 8'h5A) begin n_err++; $display("FAIL bounce_data: got %h want 5a", instruction); end
    endtask

    task automatic test_full();
        for (int a = 1; a < 255; a++) press(8'(a) ^ 8'h3C);
        n_vec++; if (wr_ptr !== 8'hFF || full !== 1'b0 || prog_len !== 9'd255) begin
            n_err++; $display("FAIL pre_full: wr_ptr=%h full=%b prog_len=%0d want ff/0/255", wr_ptr, full, prog_len);
        end
        press(8'hFF ^ 8'h3C);
        n_vec++; if (full !== 1'b1 || wr_ptr !== 8'h00 || prog_len !== 9'd256) begin
            n_err++; $display("FAIL full: full=%b wr_ptr=%h prog_len=%0d want 1/00/256", full, wr_ptr, prog_len);
        end
        press(8'hEE);
        n_vec++; if (full !== 1'b1 || wr_ptr !== 8'h00 || prog_len !== 9'd256 || cpu_reset !== 1'b1) begin
            n_err++; $display("FAIL full_ignore: full=%b wr_ptr=%h prog_len=%0d cpu_reset=%b", full, wr_ptr, prog_len, cpu_reset);
        end
        Read_Address = 8'd0; #1;
        n_vec++; if (instruction !== 8'h5A) begin n_err++; $display("FAIL full_mem0: got %h want 5a", instruction); end
`ifdef LOADER_READBACK_EN
        n_vec++; if (last_word !== 8'hC3) begin n_err++; $display("FAIL full_last: got %h want c3", last_word); end
`endif
        load_mode = 1'b0;
        wait_release();
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL full_drop: got %b want 0", full); end
        tick();
        Read_Address = 8'hFF; #1;
        n_vec++; if (instruction !== 8'hC3) begin n_err++; $display("FAIL rd_ff: got %h want c3", instruction); end
        Read_Address = 8'h80; #1;
        n_vec++; if (instruction !== 8'hBC) begin n_err++; $display("FAIL rd_80: got %h want bc", instruction); end
    endtask

    task automatic test_coincident();
        load_mode = 1'b1;
        repeat (6) tick();
        press(8'h11);
        sw_data = 8'h22;
        btn_write = 1'b1;
        repeat (4) tick();
        load_mode = 1'b0;
        wait_release();
        n_vec++; if (prog_len !== 9'd2 || wr_ptr !== 8'd2) begin
            n_err++; $display("FAIL coincide_len: prog_len=%0d wr_ptr=%0d want 2/2", prog_len, wr_ptr);
        end
        btn_write = 1'b0;
        repeat (12) tick();
        n_vec++; if (dut.r_state !== RUN || prog_len !== 9'd2) begin
            n_err++; $display("FAIL coincide_run: state=%0d prog_len=%0d want RUN/2", dut.r_state, prog_len);
        end
        Read_Address = 8'd1; #1;
        n_vec++; if (instruction !== 8'h22) begin n_err++; $display("FAIL coincide_rd1: got %h want 22", instruction); end
        Read_Address = 8'd0; #1;
        n_vec++; if (instruction !== 8'h11) begin n_err++; $display("FAIL coincide_rd0: got %h want 11", instruction); end
        Read_Address = 8'd2; #1;
        n_vec++; if (instruction !== FILL) begin n_err++; $display("FAIL coincide_rd2: got %h want %h", instruction, FILL); end
    endtask

    task automatic test_reset_midload();
        load_mode = 1'b1;
        repeat (6) tick();
        press(8'h33); press(8'h44);
        n_vec++; if (prog_len !== 9'd2) begin n_err++; $display("FAIL midload_len: got %0d want 2", prog_len); end
        Read_Address = 8'd0;
        #2 reset = 1'b1;
        #1;
        n_vec++; if (dut.r_state !== RUN || prog_len !== 9'd0 || wr_ptr !== 8'd0) begin
            n_err++; $display("FAIL midload_rst: state=%0d prog_len=%0d wr_ptr=%0d want RUN/0/0", dut.r_state, prog_len, wr_ptr);
        end
        n_vec++; if (instruction !== FILL || cpu_reset !== 1'b0 || last_word !== 8'h00) begin
            n_err++; $display("FAIL midload_outs: instr=%h cpu_reset=%b last=%h want %h/0/00", instruction, cpu_reset, last_word, FILL);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 10 && cpu_reset !== 1'b1; i++) tick();
        n_vec++; if (dut.r_state !== LOAD || cpu_reset !== 1'b1 || prog_len !== 9'd0) begin
            n_err++; $display("FAIL reenter_load: state=%0d cpu_reset=%b prog_len=%0d want LOAD/1/0", dut.r_state, cpu_reset, prog_len);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_load();
        test_bounce();
        test_full();
        test_coincident();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
